// File: rtl/counter_updown_mod.sv
// counter_updown_mod: parametrised up/down modulo counter (0..MAX) with an
// enable prescaler, synchronous clear and load, and wrap or saturate at the
// bounds. tc is combinational from count/up; wrap is a registered pulse that
// coincides with the post-wrap count.
module counter_updown_mod #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MAX      = 2**WIDTH - 1,
    parameter bit          SATURATE = 1'b0,
    parameter int          PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap
);

    // Highest legal count for this width, computed wide so WIDTH=32 does not overflow.
    localparam longint unsigned RANGE_TOP = (64'd1 << WIDTH) - 64'd1;
    localparam logic [WIDTH-1:0] MAX_V    = WIDTH'(MAX);
    localparam int PW                     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    // Elaboration-time parameter legality checks.
    generate
        if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
            $error("counter_updown_mod: WIDTH must be in 1..32");
        end
        if (MAX < 1 || 64'(MAX) > RANGE_TOP) begin : g_bad_max
            $error("counter_updown_mod: MAX must be in 1..2**WIDTH-1");
        end
        if (PRESCALE < 1) begin : g_bad_prescale
            $error("counter_updown_mod: PRESCALE must be >= 1");
        end
    endgenerate

    logic             step;
    logic [WIDTH-1:0] load_clamped;

    // A load above MAX is clamped so no path can leave count outside 0..MAX.
    assign load_clamped = (load_val > MAX_V) ? MAX_V : load_val;

    generate
        if (PRESCALE == 1) begin : g_no_presc
            assign step = en;
        end else begin : g_presc
            localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
            logic [PW-1:0] presc;

            assign step = en && (presc == PRESC_LAST);

            // Prescaler phase: restart on clear/load, advance on enabled cycles, freeze when idle.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    presc <= '0;
                end else if (clr || load) begin
                    presc <= '0;
                end else if (en) begin
                    presc <= step ? '0 : presc + PW'(1);
                end
            end
        end
    endgenerate

    // Count and wrap pulse with priority clr > load > step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            wrap  <= 1'b0;
        end else begin
            // NOTE: non-blocking everywhere in clocked logic; this early default is overridden only by a wrapping step below.
            wrap <= 1'b0;
            if (clr) begin
                count <= '0;
            end else if (load) begin
                count <= load_clamped;
            end else if (step) begin
                if (up) begin
                    if (count != MAX_V) begin
                        count <= count + WIDTH'(1);
                    end else if (!SATURATE) begin
                        count <= '0;
                        wrap  <= 1'b1;
                    end
                end else begin
                    if (count != '0) begin
                        count <= count - WIDTH'(1);
                    end else if (!SATURATE) begin
                        count <= MAX_V;
                        wrap  <= 1'b1;
                    end
                end
            end
        end
    end

    // Terminal count follows up with no register delay.
    assign tc = up ? (count == MAX_V) : (count == '0);

endmodule
